// File: rtl/ex_operand_stage.sv
// EX-stage operand register with MEM/WB forwarding, load-use stall and flush bubbles.
// Produces the ALU operands, store data and registered control for the execute stage.
module ex_operand_stage #(
    parameter int DATA_WIDTH     = 32,
    parameter int OPCODE_LENGTH  = 4,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      id_valid,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs1_addr,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs2_addr,
    input  logic [REG_ADDR_WIDTH-1:0] id_rd_addr,
    input  logic [DATA_WIDTH-1:0]     id_rs1_data,
    input  logic [DATA_WIDTH-1:0]     id_rs2_data,
    input  logic [DATA_WIDTH-1:0]     id_imm,
    input  logic                      id_alu_src,
    input  logic [OPCODE_LENGTH-1:0]  id_operation,
    input  logic                      id_reg_write,
    input  logic                      id_mem_read,
    input  logic                      flush,
    input  logic [REG_ADDR_WIDTH-1:0] mem_rd_addr,
    input  logic                      mem_reg_write,
    input  logic [DATA_WIDTH-1:0]     mem_result,
    input  logic [REG_ADDR_WIDTH-1:0] wb_rd_addr,
    input  logic                      wb_reg_write,
    input  logic [DATA_WIDTH-1:0]     wb_result,
    output logic [DATA_WIDTH-1:0]     SrcA,
    output logic [DATA_WIDTH-1:0]     SrcB,
    output logic [OPCODE_LENGTH-1:0]  Operation,
    output logic                      ex_valid,
    output logic                      ex_reg_write,
    output logic                      ex_mem_read,
    output logic [REG_ADDR_WIDTH-1:0] ex_rd_addr,
    output logic [DATA_WIDTH-1:0]     ex_store_data,
    output logic                      stall_id
);

    logic                      r_valid;
    logic [REG_ADDR_WIDTH-1:0] r_rs1_addr;
    logic [REG_ADDR_WIDTH-1:0] r_rs2_addr;
    logic [REG_ADDR_WIDTH-1:0] r_rd_addr;
    logic [DATA_WIDTH-1:0]     r_rs1_data;
    logic [DATA_WIDTH-1:0]     r_rs2_data;
    logic [DATA_WIDTH-1:0]     r_imm;
    logic                      r_alu_src;
    logic [OPCODE_LENGTH-1:0]  r_operation;
    logic                      r_reg_write;
    logic                      r_mem_read;

    logic                      w_load_use;
    logic [DATA_WIDTH-1:0]     w_rs1_fwd;
    logic [DATA_WIDTH-1:0]     w_rs2_fwd;

    // A load in EX cannot supply its data until MEM, so a dependent ID instruction waits one cycle.
    assign w_load_use = r_valid && r_mem_read && (r_rd_addr != '0) && id_valid &&
                        ((id_rs1_addr == r_rd_addr) || (id_rs2_addr == r_rd_addr));
    assign stall_id   = w_load_use && !flush;

    always_ff @(posedge clk) begin
        if (reset || flush || stall_id) begin
            r_valid     <= 1'b0;
            r_rs1_addr  <= '0;
            r_rs2_addr  <= '0;
            r_rd_addr   <= '0;
            r_rs1_data  <= '0;
            r_rs2_data  <= '0;
            r_imm       <= '0;
            r_alu_src   <= 1'b0;
            r_operation <= '0;
            r_reg_write <= 1'b0;
            r_mem_read  <= 1'b0;
        end else begin
            r_valid     <= id_valid;
            r_rs1_addr  <= id_rs1_addr;
            r_rs2_addr  <= id_rs2_addr;
            r_rd_addr   <= id_rd_addr;
            r_rs1_data  <= id_rs1_data;
            r_rs2_data  <= id_rs2_data;
            r_imm       <= id_imm;
            r_alu_src   <= id_alu_src;
            r_operation <= id_operation;
            r_reg_write <= id_reg_write;
            r_mem_read  <= id_mem_read;
        end
    end

    // MEM is younger than WB, so it wins; x0 is never forwarded.
    always_comb begin
        w_rs1_fwd = r_rs1_data;
        if (mem_reg_write && (mem_rd_addr != '0) && (mem_rd_addr == r_rs1_addr))
            w_rs1_fwd = mem_result;
        else if (wb_reg_write && (wb_rd_addr != '0) && (wb_rd_addr == r_rs1_addr))
            w_rs1_fwd = wb_result;
    end

    always_comb begin
        w_rs2_fwd = r_rs2_data;
        if (mem_reg_write && (mem_rd_addr != '0) && (mem_rd_addr == r_rs2_addr))
            w_rs2_fwd = mem_result;
        else if (wb_reg_write && (wb_rd_addr != '0) && (wb_rd_addr == r_rs2_addr))
            w_rs2_fwd = wb_result;
    end

    assign SrcA          = w_rs1_fwd;
    assign SrcB          = r_alu_src ? r_imm : w_rs2_fwd;
    assign ex_store_data = w_rs2_fwd;
    assign Operation     = r_operation;
    assign ex_valid      = r_valid;
    assign ex_reg_write  = r_reg_write;
    assign ex_mem_read   = r_mem_read;
    assign ex_rd_addr    = r_rd_addr;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed bench for ex_operand_stage: stimulus queues hand-computed expectations per cycle,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_ex_operand_stage;

    localparam int DW = 32;
    localparam int OW = 4;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic          id_valid;
    logic [AW-1:0] id_rs1_addr, id_rs2_addr, id_rd_addr;
    logic [DW-1:0] id_rs1_data, id_rs2_data, id_imm;
    logic          id_alu_src;
    logic [OW-1:0] id_operation;
    logic          id_reg_write, id_mem_read;
    logic          flush;
    logic [AW-1:0] mem_rd_addr, wb_rd_addr;
    logic          mem_reg_write, wb_reg_write;
    logic [DW-1:0] mem_result, wb_result;
    logic [DW-1:0] SrcA, SrcB, ex_store_data;
    logic [OW-1:0] Operation;
    logic          ex_valid, ex_reg_write, ex_mem_read, stall_id;
    logic [AW-1:0] ex_rd_addr;

    ex_operand_stage #(.DATA_WIDTH(DW), .OPCODE_LENGTH(OW), .REG_ADDR_WIDTH(AW)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr), .id_rd_addr(id_rd_addr),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_alu_src(id_alu_src), .id_operation(id_operation),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .flush(flush),
        .mem_rd_addr(mem_rd_addr), .mem_reg_write(mem_reg_write), .mem_result(mem_result),
        .wb_rd_addr(wb_rd_addr), .wb_reg_write(wb_reg_write), .wb_result(wb_result),
        .SrcA(SrcA), .SrcB(SrcB), .Operation(Operation), .ex_valid(ex_valid),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_rd_addr(ex_rd_addr),
        .ex_store_data(ex_store_data), .stall_id(stall_id)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            cyc;
        string         tag;
        logic [DW-1:0] srca, srcb, store;
        logic [OW-1:0] op;
        logic          v, rw, mr, stall;
        logic [AW-1:0] rd;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input string fld, input logic [DW-1:0] act,
                       input logic [DW-1:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s.%s: got %h expected %h (cycle %0d)", tag, fld, act, expv, cyc);
        end
    endtask

    // monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (q.size() > 0 && q[0].cyc <= cyc) begin
                e = q.pop_front();
                if (e.cyc != cyc) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL %s.stale: expectation for cycle %0d seen at cycle %0d",
                             e.tag, e.cyc, cyc);
                end else begin
                    chk(e.tag, "SrcA", SrcA, e.srca);
                    chk(e.tag, "SrcB", SrcB, e.srcb);
                    chk(e.tag, "store", ex_store_data, e.store);
                    chk(e.tag, "Operation", DW'(Operation), DW'(e.op));
                    chk(e.tag, "ex_valid", DW'(ex_valid), DW'(e.v));
                    chk(e.tag, "ex_reg_write", DW'(ex_reg_write), DW'(e.rw));
                    chk(e.tag, "ex_mem_read", DW'(ex_mem_read), DW'(e.mr));
                    chk(e.tag, "ex_rd_addr", DW'(ex_rd_addr), DW'(e.rd));
                    chk(e.tag, "stall_id", DW'(stall_id), DW'(e.stall));
                end
            end
        end
    end

    task automatic set_id(input logic v, input int rs1, input logic [DW-1:0] d1,
                          input int rs2, input logic [DW-1:0] d2, input int rd,
                          input logic [DW-1:0] imm, input logic asrc, input int op,
                          input logic rw, input logic mr);
        id_valid     = v;
        id_rs1_addr  = AW'(rs1);
        id_rs1_data  = d1;
        id_rs2_addr  = AW'(rs2);
        id_rs2_data  = d2;
        id_rd_addr   = AW'(rd);
        id_imm       = imm;
        id_alu_src   = asrc;
        id_operation = OW'(op);
        id_reg_write = rw;
        id_mem_read  = mr;
    endtask

    task automatic set_fwd(input int mrd, input logic mw, input logic [DW-1:0] mres,
                           input int wrd, input logic ww, input logic [DW-1:0] wres);
        mem_rd_addr   = AW'(mrd);
        mem_reg_write = mw;
        mem_result    = mres;
        wb_rd_addr    = AW'(wrd);
        wb_reg_write  = ww;
        wb_result     = wres;
    endtask

    task automatic expect_now(input string tag, input logic [DW-1:0] sa, input logic [DW-1:0] sb,
                              input logic [DW-1:0] st, input int op, input logic v,
                              input logic rw, input logic mr, input int rd, input logic stall);
        exp_t e;
        e.cyc = cyc; e.tag = tag; e.srca = sa; e.srcb = sb; e.store = st;
        e.op = OW'(op); e.v = v; e.rw = rw; e.mr = mr; e.rd = AW'(rd); e.stall = stall;
        q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic id_idle();
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic id_load();
        set_id(1, 5, 32'h50, 0, 0, 4, 32'h8, 1, 0, 1, 1);
    endtask

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        id_idle();
        set_fwd(0, 0, 0, 0, 0, 0);
        step();
        step();
        expect_now("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0);

        step(); reset = 1'b0;
        set_id(1, 1, 32'd5, 2, 32'd7, 6, 0, 0, 4'b0010, 1, 0);
        expect_now("post_reset", 0, 0, 0, 0, 0, 0, 0, 0, 0);

        step();
        set_id(1, 3, 32'h11, 0, 0, 7, 0, 0, 3, 1, 0);
        set_fwd(3, 1, 32'hAA, 3, 1, 32'hBB);
        expect_now("passthru", 5, 7, 7, 4'b0010, 1, 1, 0, 6, 0);

        step();
        expect_now("fwd_mem_prio", 32'hAA, 0, 0, 3, 1, 1, 0, 7, 0);

        step();
        id_load();
        set_fwd(3, 0, 32'hAA, 3, 1, 32'hBB);
        expect_now("fwd_wb", 32'hBB, 0, 0, 3, 1, 1, 0, 7, 0);

        step();
        set_fwd(0, 0, 0, 0, 0, 0);
        set_id(1, 9, 32'h90, 4, 32'h40, 8, 0, 0, 1, 1, 0);
        expect_now("load_use_stall", 32'h50, 32'h8, 0, 0, 1, 1, 1, 4, 1);

        step();
        expect_now("load_use_bubble", 0, 0, 0, 0, 0, 0, 0, 0, 0);

        step();
        id_load();
        expect_now("load_use_reload", 32'h90, 32'h40, 32'h40, 1, 1, 1, 0, 8, 0);

        step();
        set_id(1, 9, 32'h90, 4, 32'h40, 8, 0, 0, 1, 1, 0);
        flush = 1'b1;
        expect_now("flush_over_stall", 32'h50, 32'h8, 0, 0, 1, 1, 1, 4, 0);

        step();
        flush = 1'b0;
        set_id(1, 0, 0, 0, 0, 1, 0, 0, 5, 1, 0);
        expect_now("flush_bubble", 0, 0, 0, 0, 0, 0, 0, 0, 0);

        step();
        set_fwd(0, 1, 32'h55, 0, 1, 32'h66);
        set_id(1, 2, 32'h20, 6, 32'h99, 3, 32'hFFFF_FFFC, 1, 0, 0, 0);
        expect_now("x0_guard", 0, 0, 0, 5, 1, 1, 0, 1, 0);

        step();
        set_fwd(0, 0, 0, 6, 1, 32'h1234);
        id_load();
        expect_now("imm_store", 32'h20, 32'hFFFF_FFFC, 32'h1234, 0, 1, 0, 0, 3, 0);

        step();
        set_fwd(0, 0, 0, 0, 0, 0);
        set_id(1, 4, 32'h44, 0, 0, 8, 0, 0, 1, 1, 0);
        reset = 1'b1;
        expect_now("reset_mid_stall", 32'h50, 32'h8, 0, 0, 1, 1, 1, 4, 1);

        step();
        reset = 1'b0;
        id_idle();
        expect_now("reset_restart", 0, 0, 0, 0, 0, 0, 0, 0, 0);

        step();
        expect_now("no_survivor", 0, 0, 0, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 5 && q.size() > 0; i++) @(posedge clk);
        @(negedge clk);
        #1;
        if (q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d expectations left, required 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ex_operand_stage.md
EX_OPERAND_STAGE -- requirements
Module: ex_operand_stage

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, operand/result width.
REQ-002 SHALL have parameter OPCODE_LENGTH, default 4, ALU operation code width.
REQ-003 SHALL have parameter REG_ADDR_WIDTH, default 5, register index width.
REQ-004 SHALL have ports, one per line (name  direction  width  meaning):
- clk  in  1  single clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high reset
- id_valid  in  1  ID stage holds a real instruction
- id_rs1_addr / id_rs2_addr  in  REG_ADDR_WIDTH  source register indices
- id_rd_addr  in  REG_ADDR_WIDTH  destination register index
- id_rs1_data / id_rs2_data  in  DATA_WIDTH  register file read data
- id_imm  in  DATA_WIDTH  sign-extended immediate
- id_alu_src  in  1  1 = second ALU operand is the immediate
- id_operation  in  OPCODE_LENGTH  ALU operation code
- id_reg_write / id_mem_read  in  1  control bits travelling with the instruction
- flush  in  1  squash the instruction entering EX (taken branch/jump)
- mem_rd_addr, mem_reg_write, mem_result  in  REG_ADDR_WIDTH/1/DATA_WIDTH  MEM-stage forwarding source
- wb_rd_addr, wb_reg_write, wb_result  in  REG_ADDR_WIDTH/1/DATA_WIDTH  WB-stage forwarding source
- SrcA / SrcB  out  DATA_WIDTH  ALU operands
- Operation  out  OPCODE_LENGTH  ALU operation code
- ex_valid, ex_reg_write, ex_mem_read  out  1  registered control bits
- ex_rd_addr  out  REG_ADDR_WIDTH  registered destination index
- ex_store_data  out  DATA_WIDTH  forwarded rs2 value for stores
- stall_id  out  1  hold PC and IF/ID register this cycle
REQ-005 SHALL use one clock (clk); reset is synchronous and active-high (reset).

Function
REQ-006 SHALL hold one EX-stage register set: valid, rs1/rs2/rd addresses, rs1/rs2 data, imm, alu_src, Operation, reg_write, mem_read.
REQ-007 SHALL load ID inputs into the register set on each rising edge when reset=0, flush=0, stall_id=0; ID-to-EX latency exactly one cycle.
REQ-008 SHALL assert stall_id combinationally when ex_valid & ex_mem_read & ex_rd_addr!=0 & id_valid & (id_rs1_addr==ex_rd_addr | id_rs2_addr==ex_rd_addr), and flush=0.
REQ-009 SHALL load a bubble (all stage registers zero) on an edge where stall_id=1; the ID instruction reloads on the following edge.
REQ-010 SHALL load a bubble on an edge where flush=1; flush has priority over stall and forces stall_id=0.
REQ-011 SHALL forward per operand combinationally: MEM match (mem_reg_write & mem_rd_addr!=0 & mem_rd_addr==registered rs) -> mem_result; else WB match (same rule) -> wb_result; else registered register-file data.
REQ-012 SHALL give MEM priority over WB when both match the same operand.
REQ-013 SHALL never forward for register index 0; x0 operands use registered data.
REQ-014 SHALL drive SrcA = forwarded rs1; SrcB = id_alu_src-registered ? registered imm : forwarded rs2; ex_store_data = forwarded rs2 regardless of alu_src.
REQ-015 SHALL drive Operation, ex_valid, ex_reg_write, ex_mem_read, ex_rd_addr directly from the register set (no combinational path from ID inputs).
REQ-016 SHALL keep forwarding active when ex_valid=0; downstream ignores results of invalid slots.
REQ-017 SHALL perform no arithmetic; all data paths DATA_WIDTH wide, no truncation or extension.

Reset
REQ-018 SHALL clear every stage register to zero on a rising edge with reset=1, overriding flush and stall.
REQ-019 SHALL present after reset: ex_valid=0, ex_reg_write=0, ex_mem_read=0, ex_rd_addr=0, Operation=0; SrcA/SrcB/ex_store_data=0 unless a forwarding match on index 0 (impossible), so 0; stall_id=0.
REQ-020 SHALL treat reset asserted mid-stall as a clean restart: no held instruction survives.

Verification
REQ-021 Pass-through: id rs1=1 data 5, rs2=2 data 7, alu_src=0, op 4'b0010, no forwarding -> next cycle SrcA=5, SrcB=7, Operation=4'b0010, ex_valid=1.
REQ-022 Forward priority: registered rs1=3; mem_rd=3 result 0xAA, wb_rd=3 result 0xBB, both write -> SrcA=0xAA; drop mem_reg_write -> SrcA=0xBB.
REQ-023 Load-use: EX holds load to rd=4; ID reads rs2=4 -> stall_id=1 that cycle, next cycle ex_valid=0, following cycle ID instruction in EX with stall_id=0.
REQ-024 Flush vs stall: load-use condition plus flush=1 -> stall_id=0, next cycle bubble (ex_valid=0, ex_reg_write=0).
REQ-025 x0 guard: registered rs1=0 data 0, mem_rd=0 mem_reg_write=1 result 0x55 -> SrcA=0.
REQ-026 Immediate/store: alu_src=1, imm 0xFFFFFFFC, rs2 forwarded from WB 0x1234 -> SrcB=0xFFFFFFFC, ex_store_data=0x1234.
